// File: rtl/rv32i_types.sv
// Shared physical-memory types for the core's memory port and its responder.
package rv32i_types;

  typedef logic [255:0] physical_mem_word;
  typedef logic [31:0]  physical_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    GAP
  } pmem_resp_state_t;

  localparam int unsigned LINE_BYTES = 32;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line store: per-byte write enable, registered read, no reset on contents.
module pmem_line_array
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] idx,
  input  physical_mem_word      wdata,
  input  physical_mem_wmask     wmask,
  output physical_mem_word      rdata
);

  localparam int unsigned LINES = 1 << DEPTH_BITS;

  physical_mem_word mem [LINES];

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[idx];
    end
    if (we) begin
      for (int unsigned i = 0; i < LINE_BYTES; i++) begin
        if (wmask[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical memory server: one pmem_resp pulse per held line read/write.
module pmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned LATENCY    = 8,
  parameter int unsigned DEPTH_BITS = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  physical_mem_wmask pmem_wmask,
  input  logic [31:0]       pmem_addr,
  input  physical_mem_word  pmem_wdata,
  output logic              pmem_resp,
  output physical_mem_word  pmem_rdata,
  output logic              proto_err
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  pmem_resp_state_t      state;
  logic [7:0]            cnt;
  logic                  op_write;
  logic [DEPTH_BITS-1:0] idx_q;
  physical_mem_word      wdata_q;
  physical_mem_wmask     wmask_q;
  logic                  resp_q;
  logic                  rd_valid;
  logic                  err_q;

  logic [DEPTH_BITS-1:0] addr_idx;
  logic [DEPTH_BITS-1:0] arr_idx;
  logic                  arr_re;
  logic                  arr_we;
  physical_mem_word      arr_rdata;
  logic                  req;
  logic                  held;
  logic                  unused_addr;

  assign addr_idx    = pmem_addr[DEPTH_BITS+4:5];
  assign unused_addr = ^{pmem_addr[31:DEPTH_BITS+5], pmem_addr[4:0]};
  assign req         = pmem_read | pmem_write;
  assign held        = op_write ? pmem_write : pmem_read;

  // The array read is issued on the edge that enters RESP so its output register
  // lines up with the response cycle; with LATENCY=1 that edge is the acceptance edge.
  always_comb begin
    arr_idx = idx_q;
    arr_re  = 1'b0;
    arr_we  = 1'b0;
    unique case (state)
      IDLE: begin
        arr_idx = addr_idx;
        arr_re  = (LATENCY == 1) && pmem_read && !pmem_write;
      end
      BUSY:    arr_re = !op_write && pmem_read && (cnt == 8'd1);
      RESP:    arr_we = op_write;
      default: ;
    endcase
  end

  pmem_line_array #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_array (
    .clk  (clk),
    .re   (arr_re),
    .we   (arr_we),
    .idx  (arr_idx),
    .wdata(wdata_q),
    .wmask(wmask_q),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      resp_q   <= 1'b0;
      rd_valid <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      resp_q   <= 1'b0;
      rd_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write <= pmem_write;
            idx_q    <= addr_idx;
            wdata_q  <= pmem_wdata;
            wmask_q  <= pmem_wmask;
            if (pmem_read && pmem_write) begin
              err_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state    <= RESP;
              cnt      <= '0;
              resp_q   <= 1'b1;
              rd_valid <= !pmem_write;
            end else begin
              state <= BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        BUSY: begin
          if (!held) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b1;
          end else if (cnt == 8'd1) begin
            state    <= RESP;
            cnt      <= '0;
            resp_q   <= 1'b1;
            rd_valid <= !op_write;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP:    state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_resp  = resp_q;
  assign pmem_rdata = rd_valid ? arr_rdata : '0;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: main instance at LATENCY=8 plus LATENCY=1/255 probes.
module tb_pmem_responder;

  localparam int unsigned LAT = 8;

  typedef struct {
    logic         is_read;
    logic [255:0] data;
    int unsigned  acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  wmask = '0;
  logic [31:0]  addr = '0;
  logic [255:0] wdata = '0;
  logic         resp;
  logic [255:0] rdata;
  logic         perr;

  logic         rd1 = 1'b0;
  logic         rd255 = 1'b0;
  logic         zero_bit = 1'b0;
  logic [31:0]  zero_w = '0;
  logic [255:0] zero_line = '0;
  logic         resp1, resp255, perr1, perr255;
  logic [255:0] rdata1, rdata255;

  int unsigned  cyc = 0;
  int unsigned  checks = 0;
  int unsigned  failures = 0;
  exp_t         sb[$];
  exp_t         e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pmem_responder #(.LATENCY(LAT), .DEPTH_BITS(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(read), .pmem_write(write),
    .pmem_wmask(wmask), .pmem_addr(addr), .pmem_wdata(wdata),
    .pmem_resp(resp), .pmem_rdata(rdata), .proto_err(perr)
  );

  pmem_responder #(.LATENCY(1), .DEPTH_BITS(10)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd1), .pmem_write(zero_bit),
    .pmem_wmask(zero_w), .pmem_addr(zero_w), .pmem_wdata(zero_line),
    .pmem_resp(resp1), .pmem_rdata(rdata1), .proto_err(perr1)
  );

  pmem_responder #(.LATENCY(255), .DEPTH_BITS(10)) u_lat255 (
    .clk(clk), .rst_n(rst_n), .pmem_read(rd255), .pmem_write(zero_bit),
    .pmem_wmask(zero_w), .pmem_addr(zero_w), .pmem_wdata(zero_line),
    .pmem_resp(resp255), .pmem_rdata(rdata255), .proto_err(perr255)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every response of the main instance is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp) begin
        if (sb.size() == 0) begin
          chk("spurious_resp", 256'(resp), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("latency", 256'(cyc - e.acc + 1), 256'(LAT));
          if (e.is_read) chk("rdata", rdata, e.data);
        end
      end else begin
        chk("rdata_idle", rdata, '0);
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [255:0] d, input logic [31:0] m, input logic [255:0] expd);
    int unsigned n;
    @(negedge clk);
    read  = rd;
    write = wr;
    addr  = a;
    wdata = d;
    wmask = m;
    sb.push_back('{rd && !wr, expd, cyc + 1});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        addr  = $urandom;
        wdata = {8{$urandom}};
        wmask = $urandom;
      end
    end while (!resp && n < LAT + 10);
    if (!resp) begin
      chk("resp_timeout", 256'(resp), 256'(1));
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic lat_probe(input bit sel1, input int unsigned L);
    int unsigned n;
    logic r;
    @(negedge clk);
    if (sel1) rd1 = 1'b1;
    else rd255 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      r = sel1 ? resp1 : resp255;
    end while (!r && n < L + 10);
    chk(sel1 ? "lat1_cycles" : "lat255_cycles", 256'(n), 256'(L));
    repeat (2) begin
      @(negedge clk);
      r = sel1 ? resp1 : resp255;
      chk("lat_gap_quiet", 256'(r), 256'(0));
    end
    rd1   = 1'b0;
    rd255 = 1'b0;
    @(negedge clk);
    r = sel1 ? resp1 : resp255;
    chk("lat_after_quiet", 256'(r), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [255:0] a5, pre11, part, five_a, c3;
    a5     = {32{8'hA5}};
    pre11  = {32{8'h11}};
    part   = {{28{8'h11}}, {4{8'hFF}}};
    five_a = {32{8'h5A}};
    c3     = {32{8'h3C}};

    repeat (2) @(negedge clk);
    chk("reset_resp", 256'(resp), 256'(0));
    chk("reset_rdata", rdata, '0);
    chk("reset_perr", 256'(perr), 256'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // read after write
    txn(1'b0, 1'b1, 32'h0000_1000, a5, '1, '0);
    txn(1'b1, 1'b0, 32'h0000_1000, '0, '0, a5);

    // partial byte mask over a preloaded line
    txn(1'b0, 1'b1, 32'h0000_0040, pre11, '1, '0);
    txn(1'b0, 1'b1, 32'h0000_0040, '1, 32'h0000_000F, '0);
    txn(1'b1, 1'b0, 32'h0000_0040, '0, '0, part);

    // upper address bits alias onto line 0
    txn(1'b0, 1'b1, 32'h0000_8000, c3 ^ a5, '1, '0);
    txn(1'b1, 1'b0, 32'h0000_0000, '0, '0, c3 ^ a5);
    chk("perr_clean", 256'(perr), 256'(0));

    // read and write together: acts as a write and flags the error
    txn(1'b1, 1'b1, 32'h0000_2000, c3, '1, '0);
    chk("perr_rw_both", 256'(perr), 256'(1));
    txn(1'b1, 1'b0, 32'h0000_2000, '0, '0, c3);

    // reset while a write is in flight
    @(negedge clk);
    write = 1'b1;
    addr  = 32'h0000_1000;
    wdata = five_a;
    wmask = '1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp", 256'(resp), 256'(0));
    chk("midrst_rdata", rdata, '0);
    chk("midrst_perr", 256'(perr), 256'(0));
    repeat (2) @(negedge clk);
    write = 1'b0;
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    txn(1'b1, 1'b0, 32'h0000_1000, '0, '0, a5);

    // read dropped while busy: no response, error flagged, back in IDLE
    @(negedge clk);
    read = 1'b1;
    addr = 32'h0000_0040;
    repeat (3) @(negedge clk);
    read = 1'b0;
    repeat (LAT + 6) @(negedge clk);
    chk("perr_drop", 256'(perr), 256'(1));
    txn(1'b1, 1'b0, 32'h0000_0040, '0, '0, part);

    // latency sweep endpoints
    lat_probe(1'b1, 1);
    lat_probe(1'b0, 255);
    chk("lat1_perr", 256'(perr1), 256'(0));

    repeat (4) @(negedge clk);
    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
# pmem_responder

Cycle-accurate physical-memory server that sits at the far end of the core's physical memory port: it accepts the cache hierarchy's 256-bit line reads and masked line writes, models a fixed access latency and returns one `pmem_resp` pulse per request. It replaces the behavioural memory model in synthesizable benches and FPGA builds. Storage is an internal line array; contents survive reset.

## Interface
Parameters:
- `LATENCY`, 8: cycles from request acceptance to `pmem_resp`; legal range 1..255.
- `DEPTH_BITS`, 10: log2 of line count (default 1024 lines = 32 KiB).

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_read`  in  1  line read request; held until `pmem_resp`.
- `pmem_write`  in  1  line write request; held until `pmem_resp`.
- `pmem_wmask`  in  32  byte enables for `pmem_wdata`; bit i covers byte i.
- `pmem_addr`  in  32  byte address; bits [4:0] ignored.
- `pmem_wdata`  in  256  write line.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `pmem_rdata`  out  256  read line; valid only while `pmem_resp`=1 for a read.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- States: IDLE, BUSY, RESP, GAP.
- IDLE: if `pmem_read|pmem_write`, capture op, line index `addr[DEPTH_BITS+4:5]`, `wdata`, `wmask`; load counter with `LATENCY-1`; go BUSY (or RESP directly if `LATENCY`=1).
- BUSY: decrement counter each cycle; at 0 go RESP. If the captured request line drops (read op and `pmem_read`=0, or write op and `pmem_write`=0), abort to IDLE, set `proto_err`, no memory update.
- RESP: `pmem_resp`=1 for exactly this cycle. Read: `pmem_rdata` = stored line. Write: bytes with mask bit set are committed at the end of this cycle; others unchanged. Next state GAP.
- GAP: one cycle; requests ignored (absorbs requestor deassert latency). Next state IDLE.
- Read and write both high at acceptance: treat as write, set `proto_err`.
- `pmem_addr` upper bits above `DEPTH_BITS+4`: ignored (address aliases/wraps).
- Address or wdata changing during BUSY: ignored; captured values used.
- `proto_err` clears only on reset.

## Timing
- Reset (async assert, sync release): state IDLE, `pmem_resp`=0, `pmem_rdata`=0, `proto_err`=0, counter 0. Line array not cleared.
- Reset mid-operation: request abandoned, no write committed, `pmem_resp` stays 0.
- Request sampled high at edge k in IDLE -> `pmem_resp` high during cycle k+`LATENCY`.
- Back-to-back: minimum 2 + `LATENCY` cycles between acceptances (RESP then GAP).
- `pmem_rdata` holds 0 outside RESP on read cycles; it is registered output, not combinational from the array.
- Written line readable by next request: write commit edge precedes any later array read.

## Structure
- `physical_mem_word` (256b) and `physical_mem_wmask` (32b) come from `rv32i_types`; add `pmem_resp_state_t` enum (IDLE/BUSY/RESP/GAP) there.
- One sub-module: `pmem_line_array`, single-port `2**DEPTH_BITS` x 256 array with per-byte write enable and registered read; no reset on storage.
- Top-level holds FSM, latency counter, capture registers, error flag.

## Test plan
- Read after write: write line 0x0000_1000 = 0xA5..A5, mask all-ones; read 0x0000_1000 -> rdata 0xA5..A5, resp exactly `LATENCY` cycles after each acceptance.
- Partial mask: preload 0x11..11 at 0x40, write 0xFF..FF mask 0x0000_000F -> read returns bytes 0-3 = 0xFF, bytes 4-31 = 0x11.
- Latency sweep: `LATENCY`=1, 8, 255 -> resp at k+1, k+8, k+255; single-cycle pulse; GAP cycle ignores still-high `pmem_read`.
- Aliasing: `DEPTH_BITS`=10, write at 0x0000_8000, read 0x0000_0000 -> same line returned.
- Protocol errors: read and write together -> write committed, `proto_err`=1; read dropped in BUSY -> no resp, IDLE, `proto_err`=1.
- Reset mid-write: assert `rst_n`=0 in BUSY -> resp never pulses, outputs 0, target line retains prior contents on subsequent read.
